wb_rtsnoc_bridge_mt: RTL and testbench

Wishbone classic slave to RTSNoC bridge, successor of the fixed-target bridge. The destination node is decoded per access from the upper Wishbone address bits, so one bridge can reach any router/local port. The command word forwards byte selects. A response-origin check discards stray packets, and a transaction timeout terminates a hung access with wb_err_o. It sits between the CPU Wishbone bus and a local RTSNoC router port.

---
 rtl/wb_rtsnoc_bridge_mt.sv | 125 ++++++++++++
 tb/tb_wb_rtsnoc_bridge_mt.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_rtsnoc_bridge_mt.sv
// wb_rtsnoc_bridge_mt: Wishbone classic slave to RTSNoC bridge with per-access target decode, origin check and timeout
module wb_rtsnoc_bridge_mt #(
  parameter int WB_OFFSET_WIDTH = 6,
  parameter int WB_NOC_DATA_WIDTH = 32,
  parameter int NOC_LOCAL_ADR = 0,
  parameter int NOC_X = 0,
  parameter int NOC_Y = 0,
  parameter int SOC_SIZE_X = 1,
  parameter int SOC_SIZE_Y = 1,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_WIDTH = 10,
  localparam int TGT_W = 3 + SOC_SIZE_X + SOC_SIZE_Y,
  localparam int WB_ADDR_WIDTH = TGT_W + WB_OFFSET_WIDTH,
  localparam int NOC_BUS_SIZE = WB_NOC_DATA_WIDTH + 2 * TGT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic                         wb_we_i,
  input  logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_i,
  output logic [WB_NOC_DATA_WIDTH-1:0] wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
  output logic                         noc_wr_o,
  output logic                         noc_rd_o,
  input  logic [NOC_BUS_SIZE-1:0]      noc_dout_i,
  input  logic                         noc_wait_i,
  input  logic                         noc_nd_i,
  output logic [7:0]                   stray_cnt_o
);
  localparam logic [2:0] IDLE = 3'd0, TX_CMD = 3'd1, TX_DATA = 3'd2, RX_WAIT = 3'd3,
                         RX_SKIP = 3'd4, RX_POP = 3'd5, ACK = 3'd6, DRAIN = 3'd7;
  localparam logic [TGT_W-1:0] OWN = {SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), 3'(NOC_LOCAL_ADR)};
  localparam logic [TIMEOUT_WIDTH-1:0] TO = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  logic [2:0] state;
  logic [TGT_W-1:0] tgt;
  logic [WB_NOC_DATA_WIDTH-1:0] tx_data;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic we;
  logic accept, timed, timeout, match;
  logic [7:0] stray_inc;
  assign noc_din_o = {OWN, tgt, tx_data};
  always_comb begin
    accept = noc_wr_o && !noc_wait_i;
    timed = state == TX_CMD || state == TX_DATA || state == RX_WAIT || state == RX_SKIP;
    timeout = timed && TIMEOUT_CYCLES != 0 && timer == TO;
    match = noc_dout_i[NOC_BUS_SIZE-1 -: TGT_W] == tgt;
    stray_inc = stray_cnt_o + 8'(stray_cnt_o != 8'hff);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      noc_wr_o <= 1'b0;
      noc_rd_o <= 1'b0;
      tx_data <= '0;
      stray_cnt_o <= '0;
      timer <= '0;
      tgt <= '0;
      we <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      noc_rd_o <= 1'b0;
      if (state != IDLE && !wb_cyc_i) begin
        noc_wr_o <= 1'b0;
        state <= IDLE;
      end else if (timeout) begin
        noc_wr_o <= 1'b0;
        wb_err_o <= 1'b1;
        state <= IDLE;
      end else begin
        if (timed) timer <= timer + 1'b1;
        case (state)
          IDLE:
            if (noc_nd_i) begin
              noc_rd_o <= 1'b1;
              stray_cnt_o <= stray_inc;
              state <= DRAIN;
            end else if (wb_cyc_i && wb_stb_i && !wb_err_o) begin
              // err is still high for the master this cycle, so its stale strobe must not restart
              tgt <= wb_adr_i[WB_ADDR_WIDTH-1 -: TGT_W];
              we <= wb_we_i;
              tx_data <= (WB_NOC_DATA_WIDTH'({2'b00, ~wb_we_i, wb_sel_i}) << (WB_NOC_DATA_WIDTH - 7))
                       | WB_NOC_DATA_WIDTH'(wb_adr_i[WB_OFFSET_WIDTH-1:0]);
              noc_wr_o <= 1'b1;
              timer <= '0;
              state <= TX_CMD;
            end
          TX_CMD:
            if (accept) begin
              if (we) tx_data <= wb_dat_i;
              noc_wr_o <= we;
              state <= we ? TX_DATA : RX_WAIT;
            end
          TX_DATA:
            if (accept) begin
              noc_wr_o <= 1'b0;
              wb_ack_o <= 1'b1;
              state <= ACK;
            end
          RX_WAIT:
            if (noc_nd_i) begin
              noc_rd_o <= 1'b1;
              if (match) wb_dat_o <= noc_dout_i[WB_NOC_DATA_WIDTH-1:0];
              else stray_cnt_o <= stray_inc;
              state <= match ? RX_POP : RX_SKIP;
            end
          RX_SKIP: state <= RX_WAIT;
          RX_POP: begin
            wb_ack_o <= 1'b1;
            state <= ACK;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_rtsnoc_bridge_mt.sv
// tb_wb_rtsnoc_bridge_mt: scoreboard bench for the multi-target Wishbone/RTSNoC bridge
module tb_wb_rtsnoc_bridge_mt;
  logic clk = 0, rst = 1;
  logic wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
  logic [10:0] wb_adr_i = '0;
  logic [3:0] wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0, wb_dat_o;
  logic wb_ack_o, wb_err_o, noc_wr_o, noc_rd_o;
  logic [41:0] noc_din_o, noc_dout_i = '0;
  logic noc_wait_i = 0, noc_nd_i = 0;
  logic [7:0] stray_cnt_o;
  wb_rtsnoc_bridge_mt #(.TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o),
    .noc_rd_o(noc_rd_o), .noc_dout_i(noc_dout_i), .noc_wait_i(noc_wait_i), .noc_nd_i(noc_nd_i),
    .stray_cnt_o(stray_cnt_o)
  );
  always #5 clk = ~clk;
  localparam logic [4:0] OWN = 5'b00000, T103 = 5'b10011, T012 = 5'b01010;
  localparam logic [10:0] ADR = 11'h4EA;
  int checks = 0, errors = 0;
  int ack_cnt = 0, err_cnt = 0, rd_cnt = 0;
  logic [41:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [41:0] held;
  logic hold_v = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) hold_v = 0;
    else begin
      ack_cnt += int'(wb_ack_o);
      err_cnt += int'(wb_err_o);
      rd_cnt += int'(noc_rd_o);
      if (wb_ack_o || wb_err_o) check("ack_err_excl", 64'(wb_ack_o && wb_err_o), 0);
      if (hold_v && noc_wr_o) check("noc_hold", noc_din_o, held);
      hold_v = noc_wr_o && noc_wait_i;
      held = noc_din_o;
      if (noc_wr_o && !noc_wait_i) begin
        if (exp_q.size() != 0) check("noc_word", noc_din_o, exp_q.pop_front());
        else check("noc_extra_word", 64'(exp_q.size()), 1);
      end
    end
  end
  task automatic xfer(input logic we, input logic [31:0] dat, output logic ack, output logic err, output int cyc);
    wb_we_i = we; wb_adr_i = ADR; wb_sel_i = 4'hF; wb_dat_i = dat; wb_cyc_i = 1; wb_stb_i = 1;
    ack = 0; err = 0; cyc = 0;
    while (!ack && !err && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      ack = wb_ack_o;
      err = wb_err_o;
    end
    if (ack && !we && rd_q.size() != 0) check("rdata", wb_dat_o, rd_q.pop_front());
    wb_cyc_i = 0; wb_stb_i = 0;
  endtask
  task automatic respond(input logic [41:0] pkt);
    noc_dout_i = pkt; noc_nd_i = 1;
    for (int i = 0; i < 40 && !noc_rd_o; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    noc_nd_i = 0;
  endtask
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    logic ack, err;
    int cyc, a0, e0, r0;
    int exp_stray = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_err", wb_err_o, 0);
    check("rst_wr", noc_wr_o, 0);
    check("rst_rd", noc_rd_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_stray", stray_cnt_o, 0);
    rst = 0;
    @(posedge clk); #1;
    // plain write, router never busy
    a0 = ack_cnt;
    exp_q.push_back({OWN, T103, 32'h1E00002A});
    exp_q.push_back({OWN, T103, 32'hDEADBEEF});
    xfer(1, 32'hDEADBEEF, ack, err, cyc);
    check("w_ack", ack, 1);
    check("w_cycles", cyc, 3);
    settle();
    check("w_ack_once", ack_cnt - a0, 1);
    check("w_words_left", exp_q.size(), 0);
    // write with the command word held off for five cycles
    a0 = ack_cnt;
    exp_q.push_back({OWN, T103, 32'h1E00002A});
    exp_q.push_back({OWN, T103, 32'hDEADBEEF});
    noc_wait_i = 1;
    fork
      xfer(1, 32'hDEADBEEF, ack, err, cyc);
      begin
        repeat (6) @(posedge clk);
        #1 noc_wait_i = 0;
      end
    join
    check("ww_ack", ack, 1);
    check("ww_cycles", cyc, 8);
    settle();
    check("ww_ack_once", ack_cnt - a0, 1);
    check("ww_words_left", exp_q.size(), 0);
    // read with a matching response
    a0 = ack_cnt; r0 = rd_cnt;
    exp_q.push_back({OWN, T103, 32'h3E00002A});
    rd_q.push_back(32'h12345678);
    fork
      xfer(0, 32'h0, ack, err, cyc);
      begin
        repeat (3) @(posedge clk);
        #1 respond({T103, OWN, 32'h12345678});
      end
    join
    check("r_ack", ack, 1);
    check("r_cycles", cyc, 5);
    settle();
    check("r_ack_once", ack_cnt - a0, 1);
    check("r_rd_pulses", rd_cnt - r0, 1);
    check("r_stray", stray_cnt_o, exp_stray);
    // read where a stray packet from 0/1/2 arrives before the real response
    a0 = ack_cnt; r0 = rd_cnt;
    exp_q.push_back({OWN, T103, 32'h3E00002A});
    rd_q.push_back(32'hCAFEF00D);
    fork
      xfer(0, 32'h0, ack, err, cyc);
      begin
        repeat (3) @(posedge clk);
        #1 respond({T012, OWN, 32'h00000BAD});
        respond({T103, OWN, 32'hCAFEF00D});
      end
    join
    exp_stray++;
    check("s_ack", ack, 1);
    check("s_cycles", cyc, 7);
    settle();
    check("s_ack_once", ack_cnt - a0, 1);
    check("s_rd_pulses", rd_cnt - r0, 2);
    check("s_stray", stray_cnt_o, exp_stray);
    // read with no response times out, then the late response is drained
    a0 = ack_cnt; e0 = err_cnt; r0 = rd_cnt;
    exp_q.push_back({OWN, T103, 32'h3E00002A});
    xfer(0, 32'h0, ack, err, cyc);
    check("t_err", err, 1);
    check("t_no_ack", ack, 0);
    check("t_cycles_in_window", 64'(cyc >= 16 && cyc <= 18), 1);
    settle();
    check("t_err_once", err_cnt - e0, 1);
    respond({T103, OWN, 32'h55555555});
    exp_stray++;
    settle();
    check("t_drain_rd", rd_cnt - r0, 1);
    check("t_drain_stray", stray_cnt_o, exp_stray);
    check("t_drain_no_ack", ack_cnt - a0, 0);
    check("t_dat_kept", wb_dat_o, 32'hCAFEF00D);
    // reset while waiting for a read response
    a0 = ack_cnt; e0 = err_cnt;
    exp_q.push_back({OWN, T103, 32'h3E00002A});
    wb_we_i = 0; wb_adr_i = ADR; wb_sel_i = 4'hF; wb_cyc_i = 1; wb_stb_i = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    check("mr_ack", wb_ack_o, 0);
    check("mr_err", wb_err_o, 0);
    check("mr_wr", noc_wr_o, 0);
    check("mr_rd", noc_rd_o, 0);
    check("mr_dat", wb_dat_o, 0);
    check("mr_stray", stray_cnt_o, 0);
    check("mr_din", noc_din_o, 0);
    wb_cyc_i = 0; wb_stb_i = 0; rst = 0;
    settle();
    check("mr_no_ack", ack_cnt - a0, 0);
    check("mr_no_err", err_cnt - e0, 0);
    check("words_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
